uart_rx_cfg: RTL and testbench

Parametrised UART receiver, successor to the fixed 8N1 receiver.
- Runtime-configurable baud divisor, data length, parity mode and stop-bit count.
- 3-sample majority voting per bit; reports parity, framing, overrun and break conditions.
- Delivers bytes on a valid/ready interface to the downstream FIFO/consumer.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_bit_sampler.sv | 69 ++++++
 rtl/uart_rx_cfg.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, receiver FSM states and the
// smallest usable baud divisor.
package uart_pkg;

    localparam int MIN_DIV = 4;

    typedef enum logic [1:0] {
        PAR_NONE     = 2'd0,
        PAR_EVEN     = 2'd1,
        PAR_ODD      = 2'd2,
        PAR_NONE_ALT = 2'd3
    } par_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2,
        ST_BRKWAIT
    } rx_state_e;

endpackage

// File: rtl/uart_bit_sampler.sv
// Line synchroniser, falling-edge detector and per-bit 3-sample majority voter.
// Bit timing restarts on 'restart' and runs while 'run' is high.
module uart_bit_sampler #(
    parameter int DIV_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             rx,
    input  logic             run,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    output logic             line,
    output logic             start_edge,
    output logic             bit_strobe,
    output logic             bit_val,
    output logic             bit_end
);

    localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [NS-1:0]    sync_q, sync_d;
    logic             prev_q, prev_d;
    logic [DIV_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             s0_q, s0_d;
    logic             s1_q, s1_d;
    logic [DIV_W-1:0] mid;

    assign line = sync_q[NS-1];
    assign mid  = (div - DIV_W'(1)) >> 1;

    always_comb begin
        sync_d    = {sync_q[NS-2:0], rx};
        prev_d    = line;
        bit_cnt_d = bit_cnt_q;
        s0_d      = s0_q;
        s1_d      = s1_q;
        if (restart) begin
            bit_cnt_d = '0;
        end else if (run) begin
            if (bit_cnt_q == mid - DIV_W'(1)) s0_d = line;
            if (bit_cnt_q == mid)             s1_d = line;
            bit_cnt_d = (bit_cnt_q >= div - DIV_W'(1)) ? '0 : bit_cnt_q + DIV_W'(1);
        end
    end

    // The third vote is the live line value, so the decision lands at mid+1.
    assign start_edge = prev_q & ~line;
    assign bit_strobe = run && (bit_cnt_q == mid + DIV_W'(1));
    assign bit_val    = (s0_q & s1_q) | (s0_q & line) | (s1_q & line);
    assign bit_end    = run && (bit_cnt_q == div - DIV_W'(1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q    <= '1;
            prev_q    <= 1'b1;
            bit_cnt_q <= '0;
            s0_q      <= 1'b1;
            s1_q      <= 1'b1;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            bit_cnt_q <= bit_cnt_d;
            s0_q      <= s0_d;
            s1_q      <= s1_d;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: frame FSM on top of uart_bit_sampler, with
// parity/framing/overrun/break reporting and a valid/ready output.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_MAX    = 9,
    parameter int DIV_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                rx,
    input  logic [DIV_W-1:0]    cfg_div,
    input  logic [3:0]          cfg_bits,
    input  logic [1:0]          cfg_parity,
    input  logic                cfg_stop2,
    output logic [DATA_MAX-1:0] rx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic                parity_err,
    output logic                frame_err,
    output logic                overrun,
    input  logic                ovr_clr,
    output logic                break_det,
    output logic                busy
);

    rx_state_e           state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [3:0]          bits_q, bits_d;
    par_mode_e           par_q, par_d;
    logic                stop2_q, stop2_d;
    logic [3:0]          idx_q, idx_d;
    logic [DATA_MAX-1:0] shreg_q, shreg_d;
    logic                pbit_q, pbit_d;
    logic                ferr_q, ferr_d;
    logic [DATA_MAX-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic                perr_q, perr_d;
    logic                frerr_q, frerr_d;
    logic                ovr_q, ovr_d;
    logic                brk_q, brk_d;
    logic                busy_q, busy_d;

    logic line, start_edge, bit_strobe, bit_val, bit_end;
    logic run, restart, complete, par_en;

    function automatic logic par_xor(input logic [DATA_MAX-1:0] d, input logic [3:0] n);
        logic p;
        p = 1'b0;
        for (int i = 0; i < DATA_MAX; i++) begin
            if (4'(i) < n) p = p ^ d[i];
        end
        return p;
    endfunction

    assign run    = (state_q != ST_IDLE) && (state_q != ST_BRKWAIT);
    assign par_en = (par_q == PAR_EVEN) || (par_q == PAR_ODD);

    uart_bit_sampler #(
        .DIV_W       (DIV_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sampler (
        .clk        (clk),
        .rstn       (rstn),
        .rx         (rx),
        .run        (run),
        .restart    (restart),
        .div        (div_q),
        .line       (line),
        .start_edge (start_edge),
        .bit_strobe (bit_strobe),
        .bit_val    (bit_val),
        .bit_end    (bit_end)
    );

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bits_d   = bits_q;
        par_d    = par_q;
        stop2_d  = stop2_q;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        pbit_d   = pbit_q;
        ferr_d   = ferr_q;
        data_d   = data_q;
        valid_d  = valid_q;
        perr_d   = perr_q;
        frerr_d  = frerr_q;
        ovr_d    = ovr_q;
        brk_d    = 1'b0;
        restart  = 1'b0;
        complete = 1'b0;

        if (valid_q && rx_ready) valid_d = 1'b0;
        if (ovr_clr)             ovr_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    restart = 1'b1;
                    state_d = ST_START;
                    div_d   = (cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_div;
                    if (cfg_bits < 4'd5)                 bits_d = 4'd5;
                    else if (cfg_bits > 4'(DATA_MAX))    bits_d = 4'(DATA_MAX);
                    else                                 bits_d = cfg_bits;
                    par_d   = par_mode_e'(cfg_parity);
                    stop2_d = cfg_stop2;
                    idx_d   = '0;
                    shreg_d = '0;
                    pbit_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            ST_START: begin
                if (bit_strobe && bit_val) state_d = ST_IDLE;
                else if (bit_end)          state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_strobe) begin
                    for (int i = 0; i < DATA_MAX; i++) begin
                        if (idx_q == 4'(i)) shreg_d[i] = bit_val;
                    end
                end
                if (bit_end) begin
                    idx_d = idx_q + 4'd1;
                    if (idx_q == bits_q - 4'd1) state_d = par_en ? ST_PARITY : ST_STOP1;
                end
            end
            ST_PARITY: begin
                if (bit_strobe) pbit_d  = bit_val;
                if (bit_end)    state_d = ST_STOP1;
            end
            ST_STOP1: begin
                if (bit_strobe) begin
                    if ((shreg_q == '0) && !(par_en && pbit_q) && !bit_val) begin
                        brk_d   = 1'b1;
                        state_d = ST_BRKWAIT;
                    end else begin
                        ferr_d = !bit_val;
                        if (!stop2_q) begin
                            complete = 1'b1;
                            state_d  = ST_IDLE;
                        end
                    end
                end else if (bit_end) begin
                    state_d = ST_STOP2;
                end
            end
            ST_STOP2: begin
                if (bit_strobe) begin
                    ferr_d   = ferr_q | !bit_val;
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_BRKWAIT: begin
                if (line) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A completed frame only lands if the output slot is free this cycle.
        if (complete) begin
            if (valid_q && !rx_ready) begin
                ovr_d = 1'b1;
            end else begin
                valid_d = 1'b1;
                data_d  = shreg_q;
                perr_d  = par_en && ((par_xor(shreg_q, bits_q) ^ pbit_q) != (par_q == PAR_ODD));
                frerr_d = ferr_d;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            div_q   <= DIV_W'(MIN_DIV);
            bits_q  <= 4'd8;
            par_q   <= PAR_NONE;
            stop2_q <= 1'b0;
            idx_q   <= '0;
            shreg_q <= '0;
            pbit_q  <= 1'b0;
            ferr_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            frerr_q <= 1'b0;
            ovr_q   <= 1'b0;
            brk_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bits_q  <= bits_d;
            par_q   <= par_d;
            stop2_q <= stop2_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            pbit_q  <= pbit_d;
            ferr_q  <= ferr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            frerr_q <= frerr_d;
            ovr_q   <= ovr_d;
            brk_q   <= brk_d;
            busy_q  <= busy_d;
        end
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = frerr_q;
    assign overrun    = ovr_q;
    assign break_det  = brk_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: a table of frames plus hand sequences for
// latency, overrun, break, glitches and mid-frame reset.
module tb_uart_rx_cfg;

    logic        clk = 1'b0;
    logic        rstn;
    logic        rx;
    logic [15:0] cfg_div;
    logic [3:0]  cfg_bits;
    logic [1:0]  cfg_parity;
    logic        cfg_stop2;
    logic [8:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        parity_err;
    logic        frame_err;
    logic        overrun;
    logic        ovr_clr;
    logic        break_det;
    logic        busy;

    always #5 clk = ~clk;

    uart_rx_cfg dut (
        .clk        (clk),
        .rstn       (rstn),
        .rx         (rx),
        .cfg_div    (cfg_div),
        .cfg_bits   (cfg_bits),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .ovr_clr    (ovr_clr),
        .break_det  (break_det),
        .busy       (busy)
    );

    typedef struct {
        int div; int bits; int par; int stop2;
        int per; int nbits; int data; int pen; int pbit; int s1; int s2;
        int exp_data; int exp_perr; int exp_ferr;
    } vec_t;

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } cap_t;

    cap_t cap_q[$];
    cap_t mon_c;
    int   brk_cnt   = 0;
    int   vld_rises = 0;
    logic vld_prev  = 1'b0;
    int   checks    = 0;
    int   failures  = 0;

    always @(negedge clk) begin
        if (rx_valid && rx_ready) begin
            mon_c.data = rx_data;
            mon_c.perr = parity_err;
            mon_c.ferr = frame_err;
            cap_q.push_back(mon_c);
        end
        if (break_det) brk_cnt++;
        if (rx_valid && !vld_prev) vld_rises++;
        vld_prev = rx_valid;
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) tick();
    endtask

    task automatic set_cfg(input int div, input int bits, input int par, input int stop2);
        cfg_div    = 16'(div);
        cfg_bits   = 4'(bits);
        cfg_parity = 2'(par);
        cfg_stop2  = 1'(stop2);
    endtask

    task automatic send_frame(input int per, input int nbits, input logic [15:0] data,
                              input int pen, input logic pbit, input int s2en,
                              input logic s1, input logic s2, input int gbit);
        drive(1'b0, per);
        for (int i = 0; i < nbits; i++) begin
            for (int c = 0; c < per; c++) begin
                rx = (i == gbit && c == 8) ? ~data[i] : data[i];
                tick();
            end
        end
        if (pen != 0) drive(pbit, per);
        drive(s1, per);
        if (s2en != 0) drive(s2, per);
        rx = 1'b1;
    endtask

    task automatic expect_one(input string name, input int d, input int pe, input int fe);
        check({name, "_count"}, cap_q.size(), 1);
        if (cap_q.size() > 0) begin
            mon_c = cap_q.pop_front();
            check({name, "_data"}, int'(mon_c.data), d);
            check({name, "_perr"}, int'(mon_c.perr), pe);
            check({name, "_ferr"}, int'(mon_c.ferr), fe);
        end
        cap_q.delete();
    endtask

    vec_t vecs[11];
    int   lat;
    int   vr;

    initial begin
        vecs[0]  = '{16,  8, 0, 0, 16, 8, 'hA5,  0, 0, 1, 1, 'h0A5, 0, 0};
        vecs[1]  = '{10,  7, 2, 1, 10, 7, 'h35,  1, 0, 1, 1, 'h035, 1, 0};
        vecs[2]  = '{10,  7, 2, 1, 10, 7, 'h35,  1, 1, 1, 1, 'h035, 0, 0};
        vecs[3]  = '{16,  8, 0, 0, 16, 8, 'h3C,  0, 0, 0, 1, 'h03C, 0, 1};
        vecs[4]  = '{16,  8, 0, 0, 16, 8, 'h55,  0, 0, 1, 1, 'h055, 0, 0};
        vecs[5]  = '{ 8,  5, 1, 0,  8, 5, 'h13,  1, 1, 1, 1, 'h013, 0, 0};
        vecs[6]  = '{12, 12, 0, 0, 12, 9, 'h1A5, 0, 0, 1, 1, 'h1A5, 0, 0};
        vecs[7]  = '{ 9,  3, 0, 0,  9, 5, 'h15,  0, 0, 1, 1, 'h015, 0, 0};
        vecs[8]  = '{ 2,  8, 0, 0,  4, 8, 'h5A,  0, 0, 1, 1, 'h05A, 0, 0};
        vecs[9]  = '{16,  8, 3, 0, 16, 8, 'hC3,  0, 0, 1, 1, 'h0C3, 0, 0};
        vecs[10] = '{12,  8, 0, 1, 12, 8, 'h96,  0, 0, 1, 0, 'h096, 0, 1};

        rstn     = 1'b0;
        rx       = 1'b1;
        rx_ready = 1'b1;
        ovr_clr  = 1'b0;
        set_cfg(16, 8, 0, 0);
        repeat (3) tick();
        check("rst_valid",   int'(rx_valid),   0);
        check("rst_data",    int'(rx_data),    0);
        check("rst_perr",    int'(parity_err), 0);
        check("rst_ferr",    int'(frame_err),  0);
        check("rst_overrun", int'(overrun),    0);
        check("rst_break",   int'(break_det),  0);
        check("rst_busy",    int'(busy),       0);
        rstn = 1'b1;
        repeat (5) tick();
        check("post_rst_busy", int'(busy), 0);

        // 8N1 0xA5: latency window and mid-frame config change ignored
        cap_q.delete();
        lat = 0;
        fork
            send_frame(16, 8, 16'hA5, 0, 1'b0, 0, 1'b1, 1'b1, -1);
            begin
                repeat (20) tick();
                set_cfg(5, 5, 1, 1);
            end
            begin
                do begin
                    tick();
                    lat++;
                end while (!rx_valid && lat < 400);
            end
        join
        drive(1'b1, 32);
        set_cfg(16, 8, 0, 0);
        check("latency_window", int'(lat >= 153 && lat <= 159), 1);
        expect_one("a5", 'h0A5, 0, 0);

        for (int v = 0; v < 11; v++) begin
            set_cfg(vecs[v].div, vecs[v].bits, vecs[v].par, vecs[v].stop2);
            tick();
            send_frame(vecs[v].per, vecs[v].nbits, 16'(vecs[v].data), vecs[v].pen,
                       1'(vecs[v].pbit), vecs[v].stop2, 1'(vecs[v].s1), 1'(vecs[v].s2), -1);
            drive(1'b1, 3 * vecs[v].per);
            expect_one($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_perr, vecs[v].exp_ferr);
        end

        // overrun: consumer stalled across two frames
        set_cfg(16, 8, 0, 0);
        rx_ready = 1'b0;
        tick();
        send_frame(16, 8, 16'h11, 0, 1'b0, 0, 1'b1, 1'b1, -1);
        drive(1'b1, 32);
        check("ovr_first_valid", int'(rx_valid), 1);
        check("ovr_first_data",  int'(rx_data),  'h011);
        check("ovr_first_flag",  int'(overrun),  0);
        send_frame(16, 8, 16'h22, 0, 1'b0, 0, 1'b1, 1'b1, -1);
        drive(1'b1, 32);
        check("ovr_held_data", int'(rx_data),  'h011);
        check("ovr_set",       int'(overrun),  1);
        check("ovr_valid",     int'(rx_valid), 1);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("ovr_cleared", int'(overrun), 0);
        rx_ready = 1'b1;
        tick();
        check("ovr_handshake_fall", int'(rx_valid), 0);
        repeat (4) tick();
        cap_q.delete();

        // break: line low for 12 bit times
        vr      = vld_rises;
        brk_cnt = 0;
        drive(1'b0, 192);
        drive(1'b1, 48);
        check("brk_pulse_cycles", brk_cnt, 1);
        check("brk_no_valid",     vld_rises - vr, 0);
        check("brk_busy_low",     int'(busy), 0);
        cap_q.delete();
        send_frame(16, 8, 16'h81, 0, 1'b0, 0, 1'b1, 1'b1, -1);
        drive(1'b1, 48);
        expect_one("after_brk", 'h081, 0, 0);

        // short low glitch on idle line is a false start
        vr = vld_rises;
        drive(1'b0, 5);
        check("idle_glitch_busy_hi", int'(busy), 1);
        drive(1'b1, 40);
        check("idle_glitch_busy_lo", int'(busy), 0);
        check("idle_glitch_no_valid", vld_rises - vr, 0);
        check("idle_glitch_no_data", cap_q.size(), 0);

        // one-clock glitch inside a data bit is outvoted
        send_frame(16, 8, 16'hFF, 0, 1'b0, 0, 1'b1, 1'b1, 3);
        drive(1'b1, 48);
        expect_one("bit_glitch", 'h0FF, 0, 0);

        // asynchronous reset mid-frame aborts with no output
        vr = vld_rises;
        drive(1'b0, 16);
        drive(1'b1, 20);
        check("abort_busy_before", int'(busy), 1);
        rstn = 1'b0;
        #1;
        check("abort_busy_async", int'(busy), 0);
        tick();
        rstn = 1'b1;
        drive(1'b1, 200);
        check("abort_no_valid", vld_rises - vr, 0);
        check("abort_no_data",  cap_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
